// File: rtl/audio_bus_pkg.sv
// Shared constants and types for the audio bus initiator: register offsets,
// FIFOSPACE field layout, FSM states and the single-transaction request.
package audio_bus_pkg;

   localparam logic [15:0] FIFOSPACE_OFS = 16'd4;
   localparam logic [15:0] LEFT_OFS      = 16'd8;
   localparam logic [15:0] RIGHT_OFS     = 16'd12;

   // FIFOSPACE: read-available counts in the low half, write-space in the high half
   localparam int RARC_LSB = 0;
   localparam int RALC_LSB = 8;
   localparam int WSRC_LSB = 16;
   localparam int WSLC_LSB = 24;

   typedef enum logic [2:0] {
      IDLE, POLL, DECIDE, RD_L, RD_R, WR_L, WR_R, GAP
   } state_t;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
   } xact_req_t;

   function automatic logic [7:0] fs_field(input logic [31:0] fs, input int lsb);
      return fs[lsb +: 8];
   endfunction

endpackage

// File: rtl/audio_bus_xact.sv
// One bridge transaction: registers address/data/strobe on start, holds them
// until acknowledge, or gives up after ACK_TIMEOUT strobe cycles.
module audio_bus_xact
   import audio_bus_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  xact_req_t   req,
   input  logic        bus_acknowledge,
   input  logic [31:0] bus_read_data,
   output logic [15:0] bus_address,
   output logic        bus_read,
   output logic        bus_write,
   output logic [31:0] bus_write_data,
   output logic        done,
   output logic        timed_out,
   output logic [31:0] rdata
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   logic [CW-1:0] cnt;
   logic          active;

   // done/timed_out are combinational so the caller reacts on the ack edge itself
   assign active    = bus_read | bus_write;
   assign done      = active & bus_acknowledge;
   assign timed_out = active & ~bus_acknowledge & (cnt == CNT_LAST);
   assign rdata     = bus_read_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_read       <= 1'b0;
         bus_write      <= 1'b0;
         bus_address    <= 16'd0;
         bus_write_data <= 32'd0;
         cnt            <= '0;
      end else if (done || timed_out) begin
         bus_read  <= 1'b0;
         bus_write <= 1'b0;
      end else if (start && !active) begin
         bus_read       <= ~req.wr;
         bus_write      <= req.wr;
         bus_address    <= req.addr;
         bus_write_data <= req.wdata;
         cnt            <= '0;
      end else if (active) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/audio_bus_initiator.sv
// Polls the audio core FIFOSPACE register and moves stereo pairs between the
// core FIFOs and the ADC/DAC valid/ready streams over the bus-master bridge.
module audio_bus_initiator
   import audio_bus_pkg::*;
#(
   parameter logic [15:0] AUDIO_BASE  = 16'h3040,
   parameter int          ACK_TIMEOUT = 1023,
   parameter int          POLL_GAP    = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [15:0] bus_address,
   output logic [3:0]  bus_byte_enable,
   output logic        bus_read,
   output logic        bus_write,
   output logic [31:0] bus_write_data,
   input  logic        bus_acknowledge,
   input  logic [31:0] bus_read_data,
   output logic [31:0] adc_left,
   output logic [31:0] adc_right,
   output logic        adc_valid,
   input  logic        adc_ready,
   input  logic [31:0] dac_left,
   input  logic [31:0] dac_right,
   input  logic        dac_valid,
   output logic        dac_ready,
   output logic        bus_error,
   input  logic        err_clr,
   output logic [15:0] drop_count
);

   localparam int GW = $clog2(POLL_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   state_t      state;
   xact_req_t   xact_req;
   logic        xact_start;
   logic        xact_done;
   logic        xact_timed_out;
   logic [31:0] xact_rdata;
   logic [31:0] fifospace;
   logic [31:0] temp_left;
   logic [31:0] dac_left_hold;
   logic [31:0] dac_right_hold;
   logic [GW-1:0] gap_cnt;
   logic [7:0]  rarc, ralc, wsrc, wslc;
   logic        rd_ok, wr_ok;

   assign bus_byte_enable = 4'hF;

   assign rarc = fs_field(fifospace, RARC_LSB);
   assign ralc = fs_field(fifospace, RALC_LSB);
   assign wsrc = fs_field(fifospace, WSRC_LSB);
   assign wslc = fs_field(fifospace, WSLC_LSB);

   // A full pair must be readable/writable; the DAC side also needs a held pair
   assign rd_ok = (ralc != 8'd0) && (rarc != 8'd0) && !adc_valid;
   assign wr_ok = (wslc != 8'd0) && (wsrc != 8'd0) && !dac_ready;

   function automatic xact_req_t mk_req(input logic wr, input logic [15:0] ofs,
                                        input logic [31:0] wdata);
      xact_req_t r;
      r.wr    = wr;
      r.addr  = AUDIO_BASE + ofs;
      r.wdata = wdata;
      return r;
   endfunction

   audio_bus_xact #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_xact (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (xact_start),
      .req            (xact_req),
      .bus_acknowledge(bus_acknowledge),
      .bus_read_data  (bus_read_data),
      .bus_address    (bus_address),
      .bus_read       (bus_read),
      .bus_write      (bus_write),
      .bus_write_data (bus_write_data),
      .done           (xact_done),
      .timed_out      (xact_timed_out),
      .rdata          (xact_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         xact_start     <= 1'b0;
         xact_req       <= '0;
         fifospace      <= 32'd0;
         temp_left      <= 32'd0;
         adc_left       <= 32'd0;
         adc_right      <= 32'd0;
         adc_valid      <= 1'b0;
         dac_left_hold  <= 32'd0;
         dac_right_hold <= 32'd0;
         dac_ready      <= 1'b1;
         bus_error      <= 1'b0;
         drop_count     <= 16'd0;
         gap_cnt        <= '0;
      end else begin
         xact_start <= 1'b0;

         if (adc_valid && adc_ready)
            adc_valid <= 1'b0;

         // Capture only while empty; write-out only starts once full
         if (dac_valid && dac_ready) begin
            dac_left_hold  <= dac_left;
            dac_right_hold <= dac_right;
            dac_ready      <= 1'b0;
         end

         if (xact_timed_out)
            bus_error <= 1'b1;
         else if (err_clr)
            bus_error <= 1'b0;

         if (xact_timed_out) begin
            // Partial ADC pair is dropped; a held DAC pair stays full for retry
            state   <= GAP;
            gap_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  xact_start <= 1'b1;
                  xact_req   <= mk_req(1'b0, FIFOSPACE_OFS, 32'd0);
                  state      <= POLL;
               end
               POLL: if (xact_done) begin
                  fifospace <= xact_rdata;
                  state     <= DECIDE;
               end
               DECIDE: begin
                  if (rd_ok) begin
                     xact_start <= 1'b1;
                     xact_req   <= mk_req(1'b0, LEFT_OFS, 32'd0);
                     state      <= RD_L;
                  end else if (wr_ok) begin
                     xact_start <= 1'b1;
                     xact_req   <= mk_req(1'b1, LEFT_OFS, dac_left_hold);
                     state      <= WR_L;
                  end else begin
                     if (ralc != 8'd0 && adc_valid && drop_count != 16'hFFFF)
                        drop_count <= drop_count + 16'd1;
                     gap_cnt <= '0;
                     state   <= GAP;
                  end
               end
               RD_L: if (xact_done) begin
                  temp_left  <= xact_rdata;
                  xact_start <= 1'b1;
                  xact_req   <= mk_req(1'b0, RIGHT_OFS, 32'd0);
                  state      <= RD_R;
               end
               RD_R: if (xact_done) begin
                  adc_left  <= temp_left;
                  adc_right <= xact_rdata;
                  adc_valid <= 1'b1;
                  if (wr_ok) begin
                     xact_start <= 1'b1;
                     xact_req   <= mk_req(1'b1, LEFT_OFS, dac_left_hold);
                     state      <= WR_L;
                  end else begin
                     state <= IDLE;
                  end
               end
               WR_L: if (xact_done) begin
                  xact_start <= 1'b1;
                  xact_req   <= mk_req(1'b1, RIGHT_OFS, dac_right_hold);
                  state      <= WR_R;
               end
               WR_R: if (xact_done) begin
                  dac_ready <= 1'b1;
                  state     <= IDLE;
               end
               GAP: begin
                  if (gap_cnt == GAP_LAST)
                     state <= IDLE;
                  else
                     gap_cnt <= gap_cnt + GW'(1);
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_audio_bus_initiator.sv
// Directed bench: a table of poll scenarios against a bridge responder model,
// plus hand-written sequences for ack timing, timeout, drops and reset.
module tb_audio_bus_initiator;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] bus_address;
   logic [3:0]  bus_byte_enable;
   logic        bus_read, bus_write;
   logic [31:0] bus_write_data;
   logic        bus_acknowledge = 1'b0;
   logic [31:0] bus_read_data = 32'd0;
   logic [31:0] adc_left, adc_right;
   logic        adc_valid;
   logic        adc_ready = 1'b0;
   logic [31:0] dac_left = 32'd0, dac_right = 32'd0;
   logic        dac_valid = 1'b0;
   logic        dac_ready;
   logic        bus_error;
   logic        err_clr = 1'b0;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   audio_bus_initiator dut (
      .clk(clk), .reset_n(reset_n),
      .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
      .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
      .bus_acknowledge(bus_acknowledge), .bus_read_data(bus_read_data),
      .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid), .adc_ready(adc_ready),
      .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid), .dac_ready(dac_ready),
      .bus_error(bus_error), .err_clr(err_clr), .drop_count(drop_count)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- bridge responder model ----------------
   typedef struct { logic w; logic [15:0] a; logic [31:0] d; int hold; } txn_t;
   txn_t log_q[$];

   int          ack_dly = 0;
   logic [15:0] noack_addr = 16'h0000;
   logic [31:0] fs_val = 32'd0;
   int          fs_shots = 0;
   logic [31:0] rd_left = 32'd0, rd_right = 32'd0;
   int          proto_err = 0;

   logic        rsp_prev = 1'b0, rsp_prev_ack = 1'b0, rsp_act, rsp_w;
   logic [15:0] rsp_a;
   logic [31:0] rsp_d;
   int          rsp_wait = 0;
   txn_t        rsp_t;

   always @(negedge clk) begin
      bus_acknowledge = 1'b0;
      if (!reset_n) begin
         rsp_prev = 1'b0;
         rsp_prev_ack = 1'b0;
      end else begin
         rsp_act = bus_read | bus_write;
         if (bus_read && bus_write) proto_err++;
         if (rsp_act) begin
            if (!rsp_prev) begin
               rsp_a = bus_address; rsp_d = bus_write_data; rsp_w = bus_write; rsp_wait = 0;
            end else if (bus_address !== rsp_a || bus_write_data !== rsp_d ||
                         bus_write !== rsp_w || rsp_prev_ack) begin
               proto_err++;
            end
            if (rsp_wait == ack_dly && !(bus_read && bus_address == noack_addr)) begin
               bus_acknowledge = 1'b1;
               case (bus_address)
                  16'h3044: begin
                     if (fs_shots > 0) begin bus_read_data = fs_val; fs_shots--; end
                     else bus_read_data = 32'd0;
                  end
                  16'h3048: bus_read_data = rd_left;
                  16'h304C: bus_read_data = rd_right;
                  default:  bus_read_data = 32'hDEAD_BEEF;
               endcase
               rsp_t.w = bus_write; rsp_t.a = bus_address;
               rsp_t.d = bus_write ? bus_write_data : bus_read_data;
               rsp_t.hold = rsp_wait + 1;
               log_q.push_back(rsp_t);
            end else begin
               rsp_wait++;
            end
         end
         rsp_prev = rsp_act;
         rsp_prev_ack = bus_acknowledge;
      end
   end

   // ---------------- vector table ----------------
   typedef logic [48:0] xt_t;   // {write, address, data}
   typedef struct {
      logic [31:0] fs, rl, rr; int dly;
      logic den; logic [31:0] dl, dr;
      int n; xt_t ex[4];
      logic av; logic [31:0] el, er;
   } vec_t;
   vec_t vecs[8];

   function automatic vec_t mkv(input logic [31:0] fs, rl, rr, input int dly,
                                input logic den, input logic [31:0] dl, dr, input int n,
                                input xt_t e0, e1, e2, e3,
                                input logic av, input logic [31:0] el, er);
      vec_t v;
      v.fs = fs; v.rl = rl; v.rr = rr; v.dly = dly; v.den = den; v.dl = dl; v.dr = dr;
      v.n = n; v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3;
      v.av = av; v.el = el; v.er = er;
      return v;
   endfunction

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic offer_dac(input logic [31:0] l, input logic [31:0] r);
      int t = 0;
      while (!dac_ready && t < 500) begin tick(); t++; end
      chk("dac_ready_before_offer", dac_ready, 1'b1);
      dac_left = l; dac_right = r; dac_valid = 1'b1;
      tick();
      dac_valid = 1'b0;
      chk("dac_captured", dac_ready, 1'b0);
   endtask

   task automatic consume_adc();
      adc_ready = 1'b1;
      tick();
      adc_ready = 1'b0;
      chk("adc_valid_cleared", adc_valid, 1'b0);
   endtask

   task automatic wait_shots();
      int t = 0;
      while (fs_shots != 0 && t < 500) begin tick(); t++; end
      chk("poll_consumed", fs_shots == 0, 1'b1);
   endtask

   initial begin
      int base, k, t, hold, idle;
      logic [15:0] d0;

      vecs[0] = mkv(32'h0000_0101, 32'h1234_0000, 32'hFEDC_0000, 0, 0, 0, 0, 2,
                    {1'b0, 16'h3048, 32'h1234_0000}, {1'b0, 16'h304C, 32'hFEDC_0000}, 0, 0,
                    1, 32'h1234_0000, 32'hFEDC_0000);
      vecs[1] = mkv(32'h0404_0000, 32'h1, 32'h2, 0, 1, 32'h0000_AAAA, 32'h0000_5555, 2,
                    {1'b1, 16'h3048, 32'h0000_AAAA}, {1'b1, 16'h304C, 32'h0000_5555}, 0, 0,
                    0, 0, 0);
      vecs[2] = mkv(32'h0000_0101, 32'h0BAD_0001, 32'h0BAD_0002, 1, 0, 0, 0, 2,
                    {1'b0, 16'h3048, 32'h0BAD_0001}, {1'b0, 16'h304C, 32'h0BAD_0002}, 0, 0,
                    1, 32'h0BAD_0001, 32'h0BAD_0002);
      vecs[3] = mkv(32'h0000_0101, 32'h8000_0001, 32'h7FFF_FFFE, 7, 0, 0, 0, 2,
                    {1'b0, 16'h3048, 32'h8000_0001}, {1'b0, 16'h304C, 32'h7FFF_FFFE}, 0, 0,
                    1, 32'h8000_0001, 32'h7FFF_FFFE);
      vecs[4] = mkv(32'h0404_0101, 32'h1111_1111, 32'h2222_2222, 1, 1, 32'h3333_3333, 32'h4444_4444, 4,
                    {1'b0, 16'h3048, 32'h1111_1111}, {1'b0, 16'h304C, 32'h2222_2222},
                    {1'b1, 16'h3048, 32'h3333_3333}, {1'b1, 16'h304C, 32'h4444_4444},
                    1, 32'h1111_1111, 32'h2222_2222);
      vecs[5] = mkv(32'h0000_0100, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[6] = mkv(32'h0000_0001, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[7] = mkv(32'h0404_0000, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ---- reset values ----
      repeat (3) tick();
      chk("rst_bus_read", bus_read, 0);
      chk("rst_bus_write", bus_write, 0);
      chk("rst_bus_address", bus_address, 0);
      chk("rst_bus_write_data", bus_write_data, 0);
      chk("rst_byte_enable", bus_byte_enable, 4'hF);
      chk("rst_adc", {adc_valid, adc_left, adc_right}, 0);
      chk("rst_dac_ready", dac_ready, 1);
      chk("rst_bus_error", bus_error, 0);
      chk("rst_drop_count", drop_count, 0);
      reset_n = 1'b1;

      // ---- table-driven poll scenarios ----
      for (int i = 0; i < 8; i++) begin
         ack_dly = vecs[i].dly; rd_left = vecs[i].rl; rd_right = vecs[i].rr;
         if (vecs[i].den) offer_dac(vecs[i].dl, vecs[i].dr);
         base = log_q.size();
         fs_val = vecs[i].fs; fs_shots = 1;
         wait_shots();
         repeat (150) tick();
         k = 0;
         for (int j = base; j < log_q.size(); j++) begin
            if (!log_q[j].w && log_q[j].a == 16'h3044) continue;
            if (k < 4) begin
               chk($sformatf("v%0d_txn%0d", i, k), {log_q[j].w, log_q[j].a, log_q[j].d}, vecs[i].ex[k]);
               chk($sformatf("v%0d_txn%0d_ack_cycles", i, k), log_q[j].hold, vecs[i].dly + 1);
            end
            k++;
         end
         chk($sformatf("v%0d_num_txn", i), k, vecs[i].n);
         chk($sformatf("v%0d_adc_valid", i), adc_valid, vecs[i].av);
         if (vecs[i].av) begin
            chk($sformatf("v%0d_adc_pair", i), {adc_left, adc_right}, {vecs[i].el, vecs[i].er});
            consume_adc();
         end
         chk($sformatf("v%0d_dac_ready", i), dac_ready, 1);
         chk($sformatf("v%0d_bus_error", i), bus_error, 0);
      end

      // ---- registered-output timing around the final acks ----
      ack_dly = 2; rd_left = 32'hA5A5_0001; rd_right = 32'hA5A5_0002;
      offer_dac(32'h0000_AAAA, 32'h0000_5555);
      fs_val = 32'h0404_0101; fs_shots = 1;
      t = 0;
      while (!(bus_read && bus_address == 16'h304C && bus_acknowledge) && t < 500) begin tick(); t++; end
      chk("rd_r_ack_seen", bus_read && bus_acknowledge, 1);
      chk("adc_valid_at_ack", adc_valid, 0);
      tick();
      chk("adc_valid_after_ack", {adc_valid, adc_left, adc_right}, {1'b1, 32'hA5A5_0001, 32'hA5A5_0002});
      t = 0;
      while (!(bus_write && bus_address == 16'h304C && bus_acknowledge) && t < 500) begin tick(); t++; end
      chk("wr_r_ack_seen", {bus_write, bus_acknowledge, bus_write_data}, {2'b11, 32'h0000_5555});
      chk("dac_ready_at_ack", dac_ready, 0);
      tick();
      chk("dac_ready_after_ack", dac_ready, 1);
      consume_adc();

      // ---- acknowledge timeout on the right-channel read ----
      ack_dly = 0; noack_addr = 16'h304C; rd_left = 32'hCAFE_0001; rd_right = 32'hCAFE_0002;
      fs_val = 32'h0000_0101; fs_shots = 1;
      t = 0;
      while (!(bus_read && bus_address == 16'h304C) && t < 500) begin tick(); t++; end
      hold = 1;
      t = 0;
      while (bus_read && t < 1100) begin tick(); hold++; t++; end
      hold--;
      chk("timeout_strobe_cycles", hold, 1023);
      chk("timeout_bus_error", bus_error, 1);
      // no-strobe cycles: the drop cycle, 16 GAP cycles after it... counted from
      // the first low cycle: 16 GAP cycles, IDLE, then the poll-launch cycle
      idle = 1;
      t = 0;
      while (!(bus_read || bus_write) && t < 100) begin tick(); idle++; t++; end
      idle--;
      chk("timeout_idle_cycles", idle, 16 + 2);
      chk("timeout_next_is_poll", {bus_read, bus_address}, {1'b1, 16'h3044});
      chk("timeout_adc_valid", adc_valid, 0);
      chk("bus_error_sticky", bus_error, 1);
      noack_addr = 16'h0000;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", bus_error, 0);

      // ---- drops while the ADC holding register is full ----
      rd_left = 32'h0F0F_1111; rd_right = 32'h0F0F_2222;
      fs_val = 32'h0000_0101; fs_shots = 1;
      wait_shots();
      repeat (40) tick();
      chk("drop_pair_loaded", {adc_valid, adc_left, adc_right}, {1'b1, 32'h0F0F_1111, 32'h0F0F_2222});
      d0 = drop_count;
      base = log_q.size();
      fs_val = 32'h0000_0202; fs_shots = 3;
      wait_shots();
      repeat (30) tick();
      chk("drop_count_delta", drop_count - d0, 3);
      k = 0;
      for (int j = base; j < log_q.size(); j++)
         if (log_q[j].w || log_q[j].a != 16'h3044) k++;
      chk("drop_no_extra_reads", k, 0);
      chk("drop_pair_unchanged", {adc_valid, adc_left, adc_right}, {1'b1, 32'h0F0F_1111, 32'h0F0F_2222});

      // ---- reset in the middle of the right-channel write ----
      ack_dly = 30;
      offer_dac(32'h0BEE_F001, 32'h0BEE_F002);
      fs_val = 32'h0404_0000; fs_shots = 1;
      t = 0;
      while (!(bus_write && bus_address == 16'h304C) && t < 500) begin tick(); t++; end
      chk("wr_r_reached", bus_write, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_reset_bus_write", bus_write, 0);
      chk("mid_reset_bus", {bus_read, bus_address, bus_write_data}, 0);
      chk("mid_reset_adc", {adc_valid, adc_left, adc_right}, 0);
      chk("mid_reset_dac_ready", dac_ready, 1);
      chk("mid_reset_err_drop", {bus_error, drop_count}, 0);
      ack_dly = 0;
      repeat (2) tick();
      reset_n = 1'b1;
      base = log_q.size();
      t = 0;
      while (log_q.size() == base && t < 100) begin tick(); t++; end
      if (log_q.size() > base)
         chk("post_reset_first_txn", {log_q[base].w, log_q[base].a}, {1'b0, 16'h3044});
      else
         chk("post_reset_first_txn_seen", 0, 1);

      chk("bus_protocol_errors", proto_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
